// File: rtl/clk_div_multi_if.sv
// Control and status bundle for the multi-channel clock/strobe divider.
// The master drives enables and loads; the slave (the divider) returns clocks, ticks and pending flags.
interface clk_div_multi_if #(
  parameter int NCH = 2,
  parameter int CW  = 16
);
  logic [NCH-1:0] en;
  logic           sync_clr;
  logic [NCH-1:0] ld;
  logic [CW-1:0]  ld_half;
  logic [NCH-1:0] clk_out;
  logic [NCH-1:0] tick;
  logic [NCH-1:0] pend;

  modport master (
    output en, sync_clr, ld, ld_half,
    input  clk_out, tick, pend
  );

  modport slave (
    input  en, sync_clr, ld, ld_half,
    output clk_out, tick, pend
  );
endinterface

// File: rtl/clk_div_multi.sv
// NCH-channel even-ratio divider (period 2*H) with 50% duty output and a rising-edge tick per channel.
// All outputs registered, one-cycle response to control inputs; no backpressure, loads are always accepted.
module clk_div_multi #(
  parameter int                  NCH      = 2,
  parameter int                  CW       = 16,
  parameter logic [NCH*CW-1:0]   DIV_INIT = {16'd1564, 16'd25000}
) (
  input  logic               clk,
  input  logic               rst,
  clk_div_multi_if.slave     bus
);

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    logic [CW-1:0] cnt;
    logic [CW-1:0] h;
    logic [CW-1:0] pending;
    logic [CW-1:0] pending_nxt;
    logic          clk_q;
    logic          tick_q;
    logic          pend_q;
    logic          at_top;

    // A load in the same cycle as an apply point wins over the stored value.
    assign pending_nxt = bus.ld[i] ? bus.ld_half : pending;
    assign at_top      = (cnt == (h - CW'(1)));

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        cnt     <= '0;
        clk_q   <= 1'b0;
        tick_q  <= 1'b0;
        pend_q  <= 1'b0;
        h       <= DIV_INIT[i*CW +: CW];
        pending <= DIV_INIT[i*CW +: CW];
      end else begin
        if (bus.ld[i]) begin
          pending <= bus.ld_half;
        end
        tick_q <= 1'b0;
        // Clear, disable and H=0 all park the channel low with cnt=0, so a new H is safe to apply.
        if (bus.sync_clr || !bus.en[i] || (h == '0)) begin
          cnt    <= '0;
          clk_q  <= 1'b0;
          h      <= pending_nxt;
          pend_q <= 1'b0;
        end else if (at_top) begin
          cnt    <= '0;
          clk_q  <= ~clk_q;
          tick_q <= ~clk_q;
          if (clk_q) begin
            h      <= pending_nxt;
            pend_q <= 1'b0;
          end else begin
            pend_q <= pend_q | bus.ld[i];
          end
        end else begin
          cnt    <= cnt + CW'(1);
          pend_q <= pend_q | bus.ld[i];
        end
      end
    end

    assign bus.clk_out[i] = clk_q;
    assign bus.tick[i]    = tick_q;
    assign bus.pend[i]    = pend_q;
  end

endmodule

// File: tb/tb_clk_div_multi.sv
// Directed bench for clk_div_multi: two channels, reset half-periods H0=4 and H1=3.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_clk_div_multi;
  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  clk_div_multi_if #(.NCH(2), .CW(16)) bus ();

  clk_div_multi #(
    .NCH      (2),
    .CW       (16),
    .DIV_INIT ({16'd3, 16'd4})
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // n cycles of channel ch at level lvl; tick expected only on the first cycle of a rise.
  task automatic seg(input int ch, input bit lvl, input int n, input bit first, input string tag);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk({tag, "_clk"}, 32'(bus.clk_out[ch]), 32'(lvl));
      chk({tag, "_tick"}, 32'(bus.tick[ch]), 32'(lvl && (i == 0) && first));
    end
  endtask

  initial begin
    n_checks     = 0;
    n_fail       = 0;
    rst          = 1'b0;
    bus.en       = 2'b00;
    bus.sync_clr = 1'b0;
    bus.ld       = 2'b00;
    bus.ld_half  = 16'd0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_clk_out", 32'(bus.clk_out), 32'd0);
    chk("rst_tick", 32'(bus.tick), 32'd0);
    chk("rst_pend", 32'(bus.pend), 32'd0);

    // Free run: ch0 H=4 (period 8), ch1 H=3 (period 6)
    rst    = 1'b1;
    bus.en = 2'b11;
    for (int k = 1; k <= 24; k++) begin
      @(negedge clk);
      chk("run_clk0", 32'(bus.clk_out[0]), 32'((k / 4) % 2));
      chk("run_tick0", 32'(bus.tick[0]), 32'((k % 8) == 4));
      chk("run_clk1", 32'(bus.clk_out[1]), 32'((k / 3) % 2));
      chk("run_tick1", 32'(bus.tick[1]), 32'((k % 6) == 3));
    end

    // Load 6 mid-high: current period completes, next is 12
    bus.en = 2'b01;
    seg(0, 1'b0, 3, 1'b0, "ld6_low");
    seg(0, 1'b1, 2, 1'b1, "ld6_high");
    bus.ld      = 2'b01;
    bus.ld_half = 16'd6;
    @(negedge clk);
    chk("ld6_pend_a", 32'(bus.pend[0]), 32'd1);
    chk("ld6_clk_a", 32'(bus.clk_out[0]), 32'd1);
    bus.ld = 2'b00;
    @(negedge clk);
    chk("ld6_pend_b", 32'(bus.pend[0]), 32'd1);
    chk("ld6_clk_b", 32'(bus.clk_out[0]), 32'd1);
    @(negedge clk);
    chk("ld6_bnd_clk", 32'(bus.clk_out[0]), 32'd0);
    chk("ld6_bnd_pend", 32'(bus.pend[0]), 32'd0);
    seg(0, 1'b0, 5, 1'b0, "h6_low");
    seg(0, 1'b1, 6, 1'b1, "h6_high");
    seg(0, 1'b0, 1, 1'b0, "h6_fall");

    // Two loads before the boundary: last (10) wins
    bus.ld      = 2'b01;
    bus.ld_half = 16'd6;
    @(negedge clk);
    chk("dbl_pend_a", 32'(bus.pend[0]), 32'd1);
    chk("dbl_clk_a", 32'(bus.clk_out[0]), 32'd0);
    bus.ld_half = 16'd10;
    @(negedge clk);
    chk("dbl_pend_b", 32'(bus.pend[0]), 32'd1);
    bus.ld = 2'b00;
    seg(0, 1'b0, 3, 1'b0, "dbl_low");
    seg(0, 1'b1, 6, 1'b1, "dbl_high");
    @(negedge clk);
    chk("dbl_bnd_clk", 32'(bus.clk_out[0]), 32'd0);
    chk("dbl_bnd_pend", 32'(bus.pend[0]), 32'd0);
    seg(0, 1'b0, 9, 1'b0, "h10_low");
    seg(0, 1'b1, 10, 1'b1, "h10_high");

    // Load coincident with the falling toggle applies to the very next period
    bus.ld      = 2'b01;
    bus.ld_half = 16'd4;
    @(negedge clk);
    chk("coin_clk", 32'(bus.clk_out[0]), 32'd0);
    chk("coin_pend", 32'(bus.pend[0]), 32'd0);
    bus.ld = 2'b00;
    seg(0, 1'b0, 3, 1'b0, "coin_low");
    seg(0, 1'b1, 3, 1'b1, "coin_high");

    // Disable at cnt=2 while high, load while disabled, re-enable
    bus.en = 2'b00;
    @(negedge clk);
    chk("dis_clk", 32'(bus.clk_out[0]), 32'd0);
    chk("dis_tick", 32'(bus.tick[0]), 32'd0);
    bus.ld      = 2'b01;
    bus.ld_half = 16'd5;
    @(negedge clk);
    chk("dis_ld_pend", 32'(bus.pend[0]), 32'd0);
    chk("dis_ld_clk", 32'(bus.clk_out[0]), 32'd0);
    bus.ld = 2'b00;
    bus.en = 2'b01;
    seg(0, 1'b0, 4, 1'b0, "reen_low");
    seg(0, 1'b1, 1, 1'b1, "reen_rise");

    // Both channels H=5 at offset phases, then sync_clr aligns them
    bus.ld      = 2'b10;
    bus.ld_half = 16'd5;
    @(negedge clk);
    bus.ld = 2'b00;
    bus.en = 2'b11;
    repeat (4) @(negedge clk);
    @(negedge clk);
    chk("off_clk0", 32'(bus.clk_out[0]), 32'd0);
    chk("off_clk1", 32'(bus.clk_out[1]), 32'd1);
    chk("off_tick1", 32'(bus.tick[1]), 32'd1);
    bus.sync_clr = 1'b1;
    @(negedge clk);
    chk("sclr_clk", 32'(bus.clk_out), 32'd0);
    chk("sclr_tick", 32'(bus.tick), 32'd0);
    bus.sync_clr = 1'b0;
    for (int j = 1; j <= 12; j++) begin
      @(negedge clk);
      chk("algn_clk0", 32'(bus.clk_out[0]), 32'((j / 5) % 2));
      chk("algn_clk1", 32'(bus.clk_out[1]), 32'((j / 5) % 2));
      chk("algn_tick", 32'(bus.tick), (j == 5) ? 32'd3 : 32'd0);
    end

    // H=1: divide by two, tick on every high cycle
    bus.en       = 2'b01;
    bus.sync_clr = 1'b1;
    bus.ld       = 2'b01;
    bus.ld_half  = 16'd1;
    @(negedge clk);
    chk("h1_clr", 32'(bus.clk_out), 32'd0);
    bus.sync_clr = 1'b0;
    bus.ld       = 2'b00;
    for (int j = 1; j <= 6; j++) begin
      @(negedge clk);
      chk("h1_clk0", 32'(bus.clk_out[0]), 32'(j % 2));
      chk("h1_tick0", 32'(bus.tick[0]), 32'(j % 2));
      chk("h1_clk1", 32'(bus.clk_out[1]), 32'd0);
    end

    // H=0 parks low after the boundary
    bus.ld      = 2'b01;
    bus.ld_half = 16'd0;
    @(negedge clk);
    chk("h0_rise_clk", 32'(bus.clk_out[0]), 32'd1);
    chk("h0_rise_pend", 32'(bus.pend[0]), 32'd1);
    bus.ld = 2'b00;
    @(negedge clk);
    chk("h0_bnd_clk", 32'(bus.clk_out[0]), 32'd0);
    chk("h0_bnd_pend", 32'(bus.pend[0]), 32'd0);
    seg(0, 1'b0, 3, 1'b0, "h0_idle");

    // Reload 2 from idle: immediate restart, period 4
    bus.ld      = 2'b01;
    bus.ld_half = 16'd2;
    @(negedge clk);
    chk("h2_ld_pend", 32'(bus.pend[0]), 32'd0);
    chk("h2_ld_clk", 32'(bus.clk_out[0]), 32'd0);
    bus.ld = 2'b00;
    seg(0, 1'b0, 1, 1'b0, "h2_low_a");
    seg(0, 1'b1, 2, 1'b1, "h2_high_a");
    seg(0, 1'b0, 2, 1'b0, "h2_low_b");
    seg(0, 1'b1, 1, 1'b1, "h2_high_b");

    // Async reset mid-high, between clock edges
    #2;
    rst = 1'b0;
    #1;
    chk("arst_clk", 32'(bus.clk_out), 32'd0);
    chk("arst_tick", 32'(bus.tick), 32'd0);
    chk("arst_pend", 32'(bus.pend), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    seg(0, 1'b0, 3, 1'b0, "post_rst_low");
    seg(0, 1'b1, 1, 1'b1, "post_rst_rise");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/clk_div_multi.md
Name: clk_div_multi

Overview:
- Parametrised multi-channel clock/strobe generator; the successor to the fixed two-output sample/marker divider.
- Each channel divides the system clock by a runtime-programmable even ratio (2*H) and drives a 50 %-duty output plus a one-cycle rising-edge tick.
- Typical use: ADC sample clock, DAC (TLV5638) update clock and frame marker.
- Ratio changes are applied glitch-free at period boundaries; channels can be phase-aligned together.

Parameters:
- NCH, 2, number of output channels (1..8).
- CW, 16, width of half-period counter and divisor registers.
- DIV_INIT, {16'd1564, 16'd25000}, packed NCH*CW reset half-periods; channel i uses bits [i*CW +: CW].

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous, active-low reset.
- en  input  NCH  per-channel run enable.
- sync_clr  input  1  synchronous restart of all channels.
- ld  input  NCH  per-channel load strobe for ld_half.
- ld_half  input  CW  new half-period value, shared by all channels.
- clk_out  output  NCH  divided clock outputs, registered.
- tick  output  NCH  one-cycle pulse in the first cycle clk_out[i] is high.
- pend  output  NCH  a loaded value is waiting for its boundary.

Behaviour:
- Reset (rst=0, async): cnt=0, clk_out=0, tick=0, pend=0, H[i]=DIV_INIT[i], pending register = DIV_INIT[i].
- Per channel, when enabled: cnt increments on each clk.
  - When cnt==H-1: clk_out toggles and cnt returns to 0.
  - Output period = 2*H clk cycles; high time = low time = H.
- First rising edge: after rst release or en rising, clk_out rises on the H-th enabled posedge.
  - Example, H=4: en high at edge 0 → clk_out=1 after edge 4, falls after edge 8.
- tick[i]: registered; high exactly in the cycle whose clk_out[i] is first 1 after a 0→1 toggle; otherwise 0.
- Load:
  - ld[i]=1 captures ld_half into pending[i] and sets pend[i].
  - A second ld before the boundary overwrites pending; the last value wins.
- Boundary: the 1→0 toggle of clk_out[i], i.e. the end of a full period.
  - H[i] is updated to pending_next and pend[i] clears.
  - pending_next is ld_half if ld[i] is high in that same cycle, else pending[i].
  - A load coinciding with the boundary therefore takes effect immediately.
- Load with en[i]=0: H[i] updates on the next cycle; pend[i] does not assert.
- H=0: the channel is held idle (clk_out=0, tick=0, cnt=0) until a non-zero H is applied.
  - The H=0 → non-zero transition is applied immediately, because the channel is idle.
- H=1: clk_out toggles every cycle (divide by 2); tick every other cycle.
- en[i]=0:
  - cnt cleared and clk_out[i] forced 0 on the next edge; tick 0.
  - A 1→0 output change caused by disable is not a boundary, but any pending value is applied.
- sync_clr=1:
  - All channels: cnt=0, clk_out=0, tick=0 on the next edge.
  - Pending values are applied.
  - Highest priority after rst. Channels restart aligned, so equal-H channels are identical thereafter.
- Priority per channel: rst > sync_clr > en=0 > count/toggle. ld capture proceeds under every condition except rst.
- cnt compare is an equality against H-1 computed at CW bits.
  - If H is lowered below the current cnt, that can only happen at a boundary where cnt is already 0.
  - The counter never wraps past H-1.
- No combinational path from inputs to outputs.

Test Plan:
- Reset release, en=2'b11, H0=4, H1=3 → clk_out0 period 8 (4 high/4 low), first rise at edge 4; clk_out1 period 6, first rise at edge 3; tick one cycle per rise.
- Running H=4, ld=1 with ld_half=6 at mid-high phase → current period completes at 8 cycles; next period 12; pend high from the ld cycle to the boundary.
- ld=6 then ld=10 before the boundary → next period 20. ld coincident with the falling toggle → the new value is used for the very next period.
- en dropped at cnt=2 while high → clk_out 0 next cycle, no tick; en re-asserted → rise after H cycles.
- Channels at H=5 and H=5 with offset phases, sync_clr pulse → both outputs 0 the next cycle, then bit-identical waveforms.
- H=1 → clk_out alternates every cycle. ld_half=0 → output parks low after the boundary. Reload to 2 → restarts immediately with period 4. Async rst mid-high → all outputs 0 immediately, with no clk edge required.
